// File: rtl/ap_seq_pkg.sv
// Shared state encoding and default widths for the ap_ctrl_hs sequencer.
package ap_seq_pkg;

    localparam int CNT_W_DEF   = 16;
    localparam int MAX_OUT_DEF = 4;
    localparam int CYC_W_DEF   = 32;
    localparam int WDOG_DEF    = 4096;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/ap_ctrl_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over inc.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ap_ctrl_sequencer.sv
// Drives an ap_ctrl_hs kernel for a programmed number of transactions with a
// bounded in-flight window, downstream back-pressure, watchdog and run stats.
module ap_ctrl_sequencer
    import ap_seq_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int MAX_OUT = MAX_OUT_DEF,
    parameter int CYC_W   = CYC_W_DEF,
    parameter int WDOG    = WDOG_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] cfg_num_txn,
    input  logic             cmd_start,
    input  logic             cmd_abort,
    input  logic             sink_ready,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             ap_continue,
    output logic             busy,
    output logic             done_pulse,
    output logic             aborted,
    output logic             err_timeout,
    output logic             err_proto,
    output logic [CNT_W-1:0] txn_issued,
    output logic [CNT_W-1:0] txn_done,
    output logic [CYC_W-1:0] first_lat,
    output logic [CYC_W-1:0] run_cycles
);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] done_q, done_d;
    logic             abort_req_q, abort_req_d;
    logic             aborted_q, aborted_d;
    logic             err_timeout_q, err_timeout_d;
    logic             err_proto_q, err_proto_d;
    logic             lat_arm_q, lat_arm_d;
    logic             lat_done_q, lat_done_d;

    logic [CNT_W-1:0] outstanding;
    logic [CYC_W-1:0] wd_cnt;
    logic             in_run, start_acc, issue, retire, timeout;

    assign in_run      = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign outstanding = issued_q - done_q;
    assign start_acc   = (state_q == ST_IDLE) && cmd_start;

    // Only registered state feeds ap_start, so it cannot drop while waiting
    // for ap_ready: outstanding can only shrink until the issue lands.
    assign ap_start    = (state_q == ST_ISSUE) && (issued_q < num_q)
                         && (outstanding < CNT_W'(MAX_OUT));
    assign ap_continue = in_run && sink_ready;

    assign issue   = ap_start && ap_ready;
    assign retire  = ap_done && ap_continue && (outstanding != '0);
    assign timeout = in_run && !issue && !retire && (wd_cnt >= CYC_W'(WDOG - 1));

    always_comb begin
        state_d       = state_q;
        num_d         = num_q;
        issued_d      = issue  ? issued_q + CNT_W'(1) : issued_q;
        done_d        = retire ? done_q + CNT_W'(1)   : done_q;
        abort_req_d   = abort_req_q | (cmd_abort & in_run);
        aborted_d     = aborted_q;
        err_timeout_d = err_timeout_q;
        err_proto_d   = err_proto_q | (in_run && ap_done && (outstanding == '0));
        lat_arm_d     = lat_arm_q | ap_start;
        lat_done_d    = lat_done_q | retire;

        case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    num_d         = cfg_num_txn;
                    issued_d      = '0;
                    done_d        = '0;
                    abort_req_d   = 1'b0;
                    aborted_d     = 1'b0;
                    err_timeout_d = 1'b0;
                    err_proto_d   = 1'b0;
                    lat_arm_d     = 1'b0;
                    lat_done_d    = 1'b0;
                    state_d       = (cfg_num_txn != '0) ? ST_ISSUE : ST_DONE;
                end
            end
            ST_ISSUE: begin
                if (timeout) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_DONE;
                end else if (issued_d == num_q) begin
                    state_d = ST_DRAIN;
                end else if (abort_req_q && (!ap_start || ap_ready)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (timeout) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_DONE;
                end else if (outstanding == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if ((state_d == ST_DONE) && (state_q != ST_DONE) && abort_req_d) begin
            aborted_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            num_q         <= '0;
            issued_q      <= '0;
            done_q        <= '0;
            abort_req_q   <= 1'b0;
            aborted_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_proto_q   <= 1'b0;
            lat_arm_q     <= 1'b0;
            lat_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            num_q         <= num_d;
            issued_q      <= issued_d;
            done_q        <= done_d;
            abort_req_q   <= abort_req_d;
            aborted_q     <= aborted_d;
            err_timeout_q <= err_timeout_d;
            err_proto_q   <= err_proto_d;
            lat_arm_q     <= lat_arm_d;
            lat_done_q    <= lat_done_d;
        end
    end

    sat_counter #(.W(CYC_W)) u_run_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (start_acc),
        .inc     (in_run),
        .count   (run_cycles)
    );

    // Counts from the first ap_start cycle up to, not including, the first retire.
    sat_counter #(.W(CYC_W)) u_lat_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (start_acc),
        .inc     (in_run && (ap_start || lat_arm_q) && !lat_done_q && !retire),
        .count   (first_lat)
    );

    sat_counter #(.W(CYC_W)) u_wdog_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (!in_run || issue || retire),
        .inc     (in_run),
        .count   (wd_cnt)
    );

    assign busy        = in_run;
    assign done_pulse  = (state_q == ST_DONE);
    assign aborted     = aborted_q;
    assign err_timeout = err_timeout_q;
    assign err_proto   = err_proto_q;
    assign txn_issued  = issued_q;
    assign txn_done    = done_q;

endmodule

// File: tb/tb_ap_ctrl_sequencer.sv
// Randomized bench for ap_ctrl_sequencer with a kernel model and a run-level reference.
module tb_ap_ctrl_sequencer;

    localparam int CNT_W   = 16;
    localparam int MAX_OUT = 3;
    localparam int CYC_W   = 16;
    localparam int WDOG    = 16;

    localparam int P_IDLE  = 0;
    localparam int P_ISSUE = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic [CNT_W-1:0] cfg_num_txn = '0;
    logic             cmd_start = 1'b0, cmd_abort = 1'b0, sink_ready = 1'b0;
    logic             ap_ready = 1'b0, ap_done = 1'b0;
    logic             ap_start, ap_continue, busy, done_pulse, aborted, err_timeout, err_proto;
    logic [CNT_W-1:0] txn_issued, txn_done;
    logic [CYC_W-1:0] first_lat, run_cycles;

    always #5 clock = ~clock;

    ap_ctrl_sequencer #(.CNT_W(CNT_W), .MAX_OUT(MAX_OUT), .CYC_W(CYC_W), .WDOG(WDOG)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cfg_num_txn (cfg_num_txn),
        .cmd_start   (cmd_start),
        .cmd_abort   (cmd_abort),
        .sink_ready  (sink_ready),
        .ap_start    (ap_start),
        .ap_ready    (ap_ready),
        .ap_done     (ap_done),
        .ap_continue (ap_continue),
        .busy        (busy),
        .done_pulse  (done_pulse),
        .aborted     (aborted),
        .err_timeout (err_timeout),
        .err_proto   (err_proto),
        .txn_issued  (txn_issued),
        .txn_done    (txn_done),
        .first_lat   (first_lat),
        .run_cycles  (run_cycles)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // stimulus knobs
    int rdy_pct = 100, sink_pct = 100, lat_lo = 3, lat_hi = 3;
    int abort_pm = 0, noise_pm = 0;
    bit force_done = 1'b0;
    int cyc = 0;
    int kq[$];
    int dut_max = 0;

    // reference run state
    int m_ph = P_IDLE, m_n = 0, m_iss = 0, m_dn = 0, m_idle = 0;
    int m_rise = -1, m_ret = -1, m_s = 0, m_lat = 0, m_run = 0;
    bit m_abreq = 0, m_abt = 0, m_tmo = 0, m_pro = 0, m_done_seen = 0;

    task automatic model_reset();
        m_ph = P_IDLE; m_n = 0; m_iss = 0; m_dn = 0; m_idle = 0;
        m_rise = -1; m_ret = -1; m_lat = 0; m_run = 0;
        m_abreq = 0; m_abt = 0; m_tmo = 0; m_pro = 0;
        kq.delete();
    endtask

    task automatic tick();
        bit e_start, e_cont, e_busy, e_pulse, iss, ret, tmo_now, latched;
        int outst, nxt, done_c;
        e_busy = (m_ph == P_ISSUE) || (m_ph == P_DRAIN);
        ap_ready   = ($urandom_range(99) < rdy_pct);
        sink_ready = ($urandom_range(99) < sink_pct);
        ap_done    = force_done || (kq.size() > 0 && kq[0] <= cyc);
        if (abort_pm > 0 && $urandom_range(999) < abort_pm) cmd_abort = 1'b1;
        if (e_busy && noise_pm > 0 && $urandom_range(999) < noise_pm) begin
            cmd_start   = 1'b1;
            cfg_num_txn = CNT_W'($urandom_range(20, 1));
        end
        #1;
        outst   = m_iss - m_dn;
        e_start = (m_ph == P_ISSUE) && (m_iss < m_n) && (outst < MAX_OUT);
        e_cont  = e_busy && sink_ready;
        e_pulse = (m_ph == P_DONE);
        chk("ap_start", ap_start, e_start);
        chk("ap_continue", ap_continue, e_cont);
        chk("busy", busy, e_busy);
        chk("done_pulse", done_pulse, e_pulse);
        chk("txn_issued", txn_issued, m_iss);
        chk("txn_done", txn_done, m_dn);
        chk("aborted", aborted, m_abt);
        chk("err_timeout", err_timeout, m_tmo);
        chk("err_proto", err_proto, m_pro);
        if (!e_busy) begin
            chk("first_lat", first_lat, m_lat);
            chk("run_cycles", run_cycles, m_run);
        end
        if (int'(txn_issued) - int'(txn_done) > dut_max) dut_max = int'(txn_issued) - int'(txn_done);

        iss = e_start && ap_ready;
        ret = ap_done && e_cont && (outst > 0);
        if (iss) kq.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
        if (ret) void'(kq.pop_front());
        if (e_start && m_rise < 0) m_rise = cyc;
        if (ret && m_ret < 0) m_ret = cyc;
        if (e_busy && ap_done && outst == 0) m_pro = 1;
        latched = m_abreq;
        if (e_busy && cmd_abort) m_abreq = 1;
        m_iss += int'(iss);
        m_dn  += int'(ret);
        tmo_now = 0;
        if (e_busy) begin
            m_idle  = (iss || ret) ? 0 : m_idle + 1;
            tmo_now = (m_idle >= WDOG);
        end else begin
            m_idle = 0;
        end
        nxt = m_ph;
        case (m_ph)
            P_IDLE: if (cmd_start) begin
                m_n = int'(cfg_num_txn); m_iss = 0; m_dn = 0;
                m_abreq = 0; m_abt = 0; m_tmo = 0; m_pro = 0;
                m_rise = -1; m_ret = -1; m_s = cyc; m_lat = 0; m_run = 0;
                kq.delete();
                nxt = (m_n != 0) ? P_ISSUE : P_DONE;
            end
            P_ISSUE: begin
                if (tmo_now) begin m_tmo = 1; nxt = P_DONE; end
                else if (m_iss == m_n || (latched && (!e_start || ap_ready))) nxt = P_DRAIN;
            end
            P_DRAIN: begin
                if (tmo_now) begin m_tmo = 1; nxt = P_DONE; end
                else if (outst == 0) nxt = P_DONE;
            end
            default: nxt = P_IDLE;
        endcase
        if (nxt == P_DONE && m_ph != P_DONE) begin
            done_c = cyc + 1;
            m_abt  = m_abt | m_abreq;
            m_run  = done_c - m_s - 1;
            m_lat  = (m_rise < 0) ? 0 : (((m_ret >= 0) ? m_ret : done_c) - m_rise);
        end
        m_ph = nxt;
        m_done_seen = e_pulse || done_pulse;
        @(posedge clock);
        cyc++;
        @(negedge clock);
        cmd_start  = 1'b0;
        cmd_abort  = 1'b0;
        force_done = 1'b0;
    endtask

    task automatic start_run(input int n);
        cfg_num_txn = CNT_W'(n);
        cmd_start   = 1'b1;
        tick();
    endtask

    task automatic run_to_done(input int limit, input string tag);
        bit got = 0;
        for (int i = 0; i < limit && !got; i++) begin
            tick();
            got = m_done_seen;
        end
        chk({tag, "_finished"}, got, 1);
    endtask

    initial begin
        int cnt;
        model_reset();
        repeat (2) @(negedge clock);
        chk("rst_ap_start", ap_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_issued", txn_issued, 0);
        chk("rst_run_cycles", run_cycles, 0);
        reset_n = 1'b1;
        tick();

        // normal run, fixed 3-cycle kernel latency
        start_run(5);
        run_to_done(60, "normal");
        chk("normal_issued", txn_issued, 5);
        chk("normal_done", txn_done, 5);
        chk("normal_first_lat", first_lat, 3);

        // in-flight window
        lat_lo = 10; lat_hi = 10; dut_max = 0;
        start_run(6);
        run_to_done(120, "window");
        chk("window_max_outstanding", dut_max, MAX_OUT);

        // back-pressure with ap_done held
        lat_lo = 2; lat_hi = 2; sink_pct = 0;
        start_run(4);
        repeat (12) tick();
        chk("bp_frozen", txn_done, 0);
        chk("bp_continue_low", ap_continue, 0);
        sink_pct = 100;
        run_to_done(60, "bp");
        chk("bp_done", txn_done, 4);

        // abort while ap_start waits for ap_ready
        lat_lo = 12; lat_hi = 12;
        start_run(10);
        tick(); tick();
        rdy_pct = 0;
        tick();
        cmd_abort = 1'b1;
        tick(); tick(); tick();
        chk("abort_start_held", ap_start, 1);
        rdy_pct = 100;
        run_to_done(60, "abort");
        chk("abort_flag", aborted, 1);
        chk("abort_issued", txn_issued, 3);
        chk("abort_drained", txn_done, 3);

        // N = 0, start ignored while busy, start beats abort in IDLE
        lat_lo = 3; lat_hi = 3;
        start_run(0);
        chk("n0_pulse", done_pulse, 1);
        chk("n0_no_start", ap_start, 0);
        tick();
        start_run(4);
        tick(); tick();
        cfg_num_txn = CNT_W'(9);
        cmd_start = 1'b1;
        tick();
        run_to_done(60, "restart_ignored");
        chk("restart_n_kept", txn_issued, 4);
        cmd_abort = 1'b1;
        start_run(2);
        run_to_done(60, "start_wins");
        chk("start_wins_not_aborted", aborted, 0);

        // ap_done with nothing outstanding
        start_run(2);
        rdy_pct = 0;
        force_done = 1'b1;
        tick();
        rdy_pct = 100;
        run_to_done(60, "proto");
        chk("proto_flag", err_proto, 1);
        chk("proto_done_count", txn_done, 2);

        // kernel never ready -> watchdog
        rdy_pct = 0;
        start_run(3);
        cnt = 0;
        m_done_seen = 0;
        while (!m_done_seen && cnt < 40) begin tick(); cnt++; end
        chk("wdog_cycles", cnt, WDOG + 1);
        chk("wdog_flag", err_timeout, 1);
        rdy_pct = 100;

        // asynchronous reset mid-run
        lat_lo = 6; lat_hi = 6;
        start_run(8);
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        chk("arst_ap_start", ap_start, 0);
        chk("arst_ap_continue", ap_continue, 0);
        chk("arst_busy", busy, 0);
        chk("arst_issued", txn_issued, 0);
        chk("arst_first_lat", first_lat, 0);
        chk("arst_run_cycles", run_cycles, 0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        tick(); tick();

        // randomized runs
        for (int r = 0; r < 25; r++) begin
            rdy_pct  = int'($urandom_range(100, 30));
            sink_pct = int'($urandom_range(100, 40));
            lat_lo   = int'($urandom_range(4, 1));
            lat_hi   = lat_lo + int'($urandom_range(4, 0));
            abort_pm = ($urandom_range(3) == 0) ? 20 : 0;
            noise_pm = 30;
            start_run(int'($urandom_range(12, 0)));
            run_to_done(400, "random");
            noise_pm = 0; abort_pm = 0;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
